// File: rtl/ref_window_fetch.sv
// ref_window_fetch: reads a 15x15 edge-clamped reference window (8x8 block, 3 pixels before
//   and 4 after on each axis) from byte-wide pixel memory, then serves one packed row per row_idx.
// Latency: start -> done = 226 cycles (225 reads, 1 drain). row_data is combinational from the window.
// Backpressure: none. start is ignored while busy. The memory must return data one cycle after mem_rd.
// Ports: clk/rst (async, active-high); start, blk_x, blk_y (fetch request, coordinates latched on
//   accept); mem_rd, mem_addr, mem_rdata (pixel memory); busy, done, win_valid (status);
//   row_idx, row_data (row read port; pixel c in bits [8c+7:8c]; row 15 reads as zero).
// Build option PINGPONG_EN: double-buffered window. The fetch fills the back bank, row_data reads
//   the front bank, and the banks swap on done.
module ref_window_fetch #(
  parameter int PIC_W  = 64,
  parameter int PIC_H  = 64,
  parameter int ADDR_W = 12,
  parameter int CRD_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CRD_W-1:0]  blk_x,
  input  logic [CRD_W-1:0]  blk_y,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              win_valid,
  input  logic [3:0]        row_idx,
  output logic [119:0]      row_data
);
  localparam int WIN = 15;
  localparam int SW  = CRD_W + 2;
`ifdef PINGPONG_EN
  localparam int NROW = 2 * WIN;
`else
  localparam int NROW = WIN;
`endif
  localparam int IW = $clog2(NROW);
  localparam logic signed [SW-1:0] PAD  = SW'(3);
  localparam logic signed [SW-1:0] XMAX = SW'(PIC_W - 1);
  localparam logic signed [SW-1:0] YMAX = SW'(PIC_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t            state_q, state_d;
  logic [CRD_W-1:0]  bx_q, by_q, bx_d, by_d;
  logic [3:0]        r_q, c_q, r_d, c_d;
  logic [3:0]        cap_r_q, cap_c_q;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              done_q, done_d;
  logic              win_valid_q, win_valid_d;
`ifdef PINGPONG_EN
  logic              front_q, front_d;
`endif
  logic [119:0]      win_q [NROW];

  logic signed [SW-1:0] xs, ys;
  logic [SW-1:0]        xa, ya;
  logic [ADDR_W-1:0]    issue_addr;
  logic [IW-1:0]        wr_row, rd_row;

  // Window coordinate of the next issue. Signed arithmetic two bits wider than the
  // block coordinates, so blk-3 never wraps and large blk+11 never overflows.
  always_comb begin
    xs = $signed({2'b00, bx_q}) - PAD + $signed({{(SW-4){1'b0}}, c_q});
    ys = $signed({2'b00, by_q}) - PAD + $signed({{(SW-4){1'b0}}, r_q});
    if (xs[SW-1])     xa = '0;
    else if (xs > XMAX) xa = XMAX;
    else              xa = xs;
    if (ys[SW-1])     ya = '0;
    else if (ys > YMAX) ya = YMAX;
    else              ya = ys;
    issue_addr = ADDR_W'(ya) * ADDR_W'(PIC_W) + ADDR_W'(xa);
  end

`ifdef PINGPONG_EN
  assign wr_row = IW'(cap_r_q) + (front_q ? IW'(0) : IW'(WIN));
  assign rd_row = IW'(row_idx) + (front_q ? IW'(WIN) : IW'(0));
`else
  assign wr_row = IW'(cap_r_q);
  assign rd_row = IW'(row_idx);
`endif

  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    by_d        = by_q;
    r_d         = r_q;
    c_d         = c_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    done_d      = 1'b0;
    win_valid_d = win_valid_q;
`ifdef PINGPONG_EN
    front_d     = front_q;
`endif
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          state_d = FETCH;
          bx_d    = blk_x;
          by_d    = blk_y;
          r_d     = '0;
          c_d     = '0;
`ifndef PINGPONG_EN
          // Single bank is overwritten in place, so its contents stop being a window.
          win_valid_d = 1'b0;
`endif
        end
      end
      FETCH: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = issue_addr;
        if (c_q == 4'd14) begin
          c_d = '0;
          if (r_q == 4'd14) begin
            r_d     = '0;
            state_d = DRAIN;
          end else begin
            r_d = r_q + 4'd1;
          end
        end else begin
          c_d = c_q + 4'd1;
        end
      end
      DRAIN: begin
        // Last byte lands this edge; the window is complete.
        state_d     = READY;
        done_d      = 1'b1;
        win_valid_d = 1'b1;
`ifdef PINGPONG_EN
        front_d     = ~front_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bx_q        <= '0;
      by_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      cap_r_q     <= '0;
      cap_c_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
`ifdef PINGPONG_EN
      front_q     <= 1'b0;
`endif
      for (int i = 0; i < NROW; i++) win_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      r_q         <= r_d;
      c_q         <= c_d;
      // Remember the position of the read in flight; its data arrives next cycle.
      cap_r_q     <= r_q;
      cap_c_q     <= c_q;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      done_q      <= done_d;
      win_valid_q <= win_valid_d;
`ifdef PINGPONG_EN
      front_q     <= front_d;
`endif
      if (mem_rd_q) win_q[wr_row][{cap_c_q, 3'b000} +: 8] <= mem_rdata;
    end
  end

  always_comb begin
    row_data = '0;
    if (row_idx != 4'd15) row_data = win_q[rd_row];
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = (state_q == FETCH) || (state_q == DRAIN);
  assign done      = done_q;
  assign win_valid = win_valid_q;

endmodule

// File: tb/tb_ref_window_fetch.sv
// Testbench for ref_window_fetch: pixel memory model, timeline-based reference model,
// per-cycle comparison of all outputs, plus directed literal checks of the window.
module tb_ref_window_fetch;
  localparam int PW = 64;
  localparam int PH = 64;

  logic         clk = 1'b0;
  logic         rst, start, mem_rd, busy, done, win_valid;
  logic [7:0]   blk_x, blk_y, mem_rdata;
  logic [11:0]  mem_addr;
  logic [3:0]   row_idx;
  logic [119:0] row_data;

  int n_chk = 0;
  int n_err = 0;
  bit rand_rows = 1'b0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ref_window_fetch #(.PIC_W(64), .PIC_H(64), .ADDR_W(12), .CRD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .win_valid(win_valid),
    .row_idx(row_idx), .row_data(row_data)
  );

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic logic [7:0] pix(int x, int y);
    return 8'((x + 3 * y) & 255);
  endfunction

  // Memory data stage: data for the address presented on one edge is read on the next.
  always_comb mem_rdata = pix(int'(mem_addr) % PW, int'(mem_addr) / PW);

  // ---------------- reference model ----------------
  // t = cycles since the accepted start edge (-1 when no fetch is in progress).
  int         t = -1;
  int         mbx = 0;
  int         mby = 0;
  bit         m_done = 1'b0;
  bit         m_valid = 1'b0;
  logic [7:0] wb [15][15];
  logic [7:0] wf [15][15];

  function automatic logic [7:0] exp_byte(int r, int c);
    return pix(clampi(mbx - 3 + c, PW - 1), clampi(mby - 3 + r, PH - 1));
  endfunction

  function automatic int exp_addr(int k);
    return clampi(mby - 3 + k / 15, PH - 1) * PW + clampi(mbx - 3 + k % 15, PW - 1);
  endfunction

  function automatic logic [119:0] model_row(int ri);
    logic [119:0] v;
    v = '0;
    if (ri < 15) begin
      for (int c = 0; c < 15; c++) begin
`ifdef PINGPONG_EN
        v[8*c +: 8] = wf[ri][c];
`else
        v[8*c +: 8] = wb[ri][c];
`endif
      end
    end
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = -1; m_done = 1'b0; m_valid = 1'b0;
      for (int i = 0; i < 15; i++)
        for (int j = 0; j < 15; j++) begin wb[i][j] = '0; wf[i][j] = '0; end
    end else begin
      m_done = 1'b0;
      if (t < 0) begin
        if (start) begin
          t = 0; mbx = int'(blk_x); mby = int'(blk_y);
`ifndef PINGPONG_EN
          m_valid = 1'b0;
`endif
        end
      end else begin
        t++;
        // byte k is issued at t=k+1 and captured at t=k+2
        if (t >= 2 && t <= 226) wb[(t-2)/15][(t-2)%15] = exp_byte((t-2)/15, (t-2)%15);
        if (t == 226) begin
          t = -1; m_done = 1'b1; m_valid = 1'b1;
          for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) wf[i][j] = wb[i][j];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", nm, act, exp, t, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("mem_rd", mem_rd, (t >= 1 && t <= 225));
      if (t >= 1 && t <= 225) chk("mem_addr", mem_addr, exp_addr(t - 1));
      chk("busy", busy, (t >= 0));
      chk("done", done, m_done);
      chk("win_valid", win_valid, m_valid);
      chk("row_data", row_data, model_row(int'(row_idx)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
    if (rand_rows) row_idx = 4'($urandom_range(0, 15));
  endtask

  task automatic run_fetch(input int bx, input int by, input int pulse_at, input int rst_at,
                           input int probe_at, output int lat, output int fa, output int ma);
    tick; start = 1'b1; blk_x = 8'(bx); blk_y = 8'(by);
    tick; start = 1'b0;
    lat = 0; fa = -1; ma = 0;
    while (lat < 400) begin
      tick; lat++;
      start = (lat == pulse_at);
      if (mem_rd) begin
        if (fa < 0) fa = int'(mem_addr);
        if (int'(mem_addr) > ma) ma = int'(mem_addr);
      end
      if (lat == rst_at) begin rst = 1'b1; return; end
      if (lat == probe_at) begin
        row_idx = 4'd0; #1;
`ifdef PINGPONG_EN
        chk("pp_valid_refetch", win_valid, 1'b1);
        chk("pp_old_window", row_data[7:0], 8'h34);
`else
        chk("sb_valid_refetch", win_valid, 1'b0);
`endif
      end
      if (done) break;
    end
    start = 1'b0;
    chk("latency", lat, 226);
  endtask

  initial begin
    int lat, fa, ma, nd;
    rst = 1'b1; start = 1'b0; blk_x = '0; blk_y = '0; row_idx = '0;
    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_win_valid", win_valid, 1'b0);
    chk("rst_row0", row_data, 120'h0);
    tick; tick; rst = 1'b0; cmp_en = 1'b1; rand_rows = 1'b1;

    // interior block
    run_fetch(16, 16, 0, 0, 0, lat, fa, ma);
    chk("t1_first_addr", fa, 13*64 + 13);
    rand_rows = 1'b0;
    row_idx = 4'd0;  #1; chk("t1_r0b0", row_data[7:0], 8'h34);
    row_idx = 4'd14; #1; chk("t1_r14b14", row_data[119:112], 8'h6C);
    rand_rows = 1'b1;

    // top-left corner
    run_fetch(0, 0, 0, 0, 0, lat, fa, ma);
    chk("t2_first_addr", fa, 0);
    chk("t2_max_addr_ok", (ma <= 14*64 + 4), 1'b1);
    rand_rows = 1'b0;
    for (int r = 0; r < 4; r++) begin
      row_idx = 4'(r); #1;
      chk("t2_clamped_bytes", row_data[31:0], 32'h0);
      chk("t2_byte4", row_data[39:32], 8'h01);
    end
    rand_rows = 1'b1;

    // bottom-right corner
    run_fetch(56, 56, 0, 0, 0, lat, fa, ma);
    rand_rows = 1'b0;
    for (int r = 0; r < 15; r++) begin
      row_idx = 4'(r); #1;
      for (int c = 11; c < 15; c++) chk("t3_right_clamp", row_data[8*c +: 8], pix(63, clampi(53 + r, 63)));
    end
    row_idx = 4'd14; #1; chk("t3_r14b14", row_data[119:112], 8'hFC);
    row_idx = 4'd0;  #1; chk("t3_r0b11", row_data[95:88], 8'hDE);
    rand_rows = 1'b1;

    // start during fetch is ignored; row 15 reads zero
    run_fetch(16, 16, 50, 0, 0, lat, fa, ma);
    rand_rows = 1'b0;
    row_idx = 4'd15; #1; chk("t4_row15", row_data, 120'h0);
    rand_rows = 1'b1;

    // reset mid-fetch
    run_fetch(16, 16, 0, 100, 0, lat, fa, ma);
    #1;
    chk("t5_rst_mem_rd", mem_rd, 1'b0);
    chk("t5_rst_win_valid", win_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    tick; rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 300; i++) begin tick; if (done) nd++; end
    chk("t5_no_done", nd, 0);
    run_fetch(40, 8, 0, 0, 0, lat, fa, ma);
    chk("t5_restart_addr", fa, 5*64 + 37);

    // back-to-back fetches: window 1 then window 2
    run_fetch(16, 16, 0, 0, 0, lat, fa, ma);
    run_fetch(0, 0, 0, 0, 100, lat, fa, ma);
    rand_rows = 1'b0;
    row_idx = 4'd0; #1; chk("t6_new_window", row_data[7:0], 8'h00);
    row_idx = 4'd5; #1; chk("t6_new_r5b5", row_data[47:40], pix(2, 2));
    rand_rows = 1'b1;

    // randomized fetches with ignored start pulses and idle gaps
    for (int i = 0; i < 6; i++) begin
      int g;
      g = $urandom_range(0, 5);
      for (int k = 0; k < g; k++) tick;
      run_fetch($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(1, 220), 0, 0, lat, fa, ma);
    end

    tick; tick;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
